axis_stat_counter_mc: RTL and testbench
=======================================

Name: axis_stat_counter_mc

Overview:
- Multi-channel AXI4-Stream statistics collector. It passively monitors CHANNELS independent streams and counts bytes (tkeep popcount) and completed frames per channel, plus one shared tick counter.
- On trigger, all counters are snapshotted and cleared atomically. The snapshot is then serialised as one byte-wide AXI-Stream status frame.
- Sits beside MAC/datapath stream taps; the status stream feeds the CSR/telemetry mux.

Parameters:
- CHANNELS, 4, number of monitored streams (1..16).
- KEEP_WIDTH, 8, tkeep bits per channel. Tick increment per cycle equals KEEP_WIDTH.
- TAG_WIDTH, 16, tag field width.
- TICK_COUNT_WIDTH, 32, tick counter width.
- BYTE_COUNT_WIDTH, 32, per-channel byte counter width.
- FRAME_COUNT_WIDTH, 32, per-channel frame counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Single clock; reset is asynchronous, active-low.
- monitor_axis_tkeep  in  CHANNELS*KEEP_WIDTH  channel c occupies bits [c*KEEP_WIDTH +: KEEP_WIDTH].
- monitor_axis_tvalid  in  CHANNELS  per-channel valid.
- monitor_axis_tready  in  CHANNELS  per-channel ready.
- monitor_axis_tlast  in  CHANNELS  per-channel last.
- m_axis_tdata  out  8  status byte.
- m_axis_tvalid  out  1  status valid.
- m_axis_tready  in  1  status ready.
- m_axis_tlast  out  1  last status byte.
- m_axis_tuser  out  1  overflow flag (see Optional Feature).
- tag  in  TAG_WIDTH  sampled on the accepted trigger.
- trigger  in  1  snapshot request, single-cycle pulse or level.
- busy  out  1  readout in progress.

Behaviour:
- Byte-width rule: XB = ceil(X_WIDTH/8). LEN = TAGB + TICKB + CHANNELS*(BYTEB+FRAMEB). The pointer is clog2(LEN) bits wide, minimum 1.
- Frame order, each field MSB byte first: tag, tick, then for c = 0..CHANNELS-1: byte_count[c], frame_count[c]. tlast is set only on byte LEN.
- Beats: a beat on channel c is tvalid[c] && tready[c]. Byte increment is popcount(tkeep[c]); any tkeep pattern is allowed, including non-contiguous. Frame count increments on a beat with tlast[c], so single-beat frames count as one.
- Tick counter adds KEEP_WIDTH every cycle rst_n is high.
- States: IDLE and READOUT.
  - IDLE, on trigger: shadow ← current counter values and tag. Each live counter ← that cycle's own increment (events in the trigger cycle belong to the new interval). Then go to READOUT.
  - READOUT: emit one byte per cycle while the internal ready is high. Return to IDLE on the cycle the byte carrying tlast enters the output stage.
  - Trigger during READOUT is ignored; counters are not cleared.
- Output stage: registered 2-entry skid buffer.
  - m_axis_tvalid is combinationally independent of m_axis_tready.
  - First byte is valid at the earliest 1 cycle after the trigger edge.
  - With tready held high, sustained rate is 1 byte/cycle.
  - No byte is lost or duplicated under any backpressure.
- busy: registered, equals (state_next != IDLE). It goes high the cycle after trigger, goes low the cycle after READOUT exits, and does not wait for the skid buffer to drain.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, busy=0. All counters, shadows, pointer, skid entries and state = 0/IDLE.
- Reset assertion mid-readout: immediate async clear; the partial frame is discarded and never resumed.
- Counter boundaries: wrap modulo 2^width unless AXIS_STAT_SATURATE_EN is defined.

Optional Feature:
- Macro: AXIS_STAT_SATURATE_EN.
- Defined: every counter clamps at all-ones. A per-interval sticky overflow bit is set on any clamp and snapshotted with the counters. m_axis_tuser = sticky bit, asserted on the tlast byte only.
- Undefined: counters wrap; m_axis_tuser is constant 0.

Decomposition:
- Package axis_stat_pkg:
  - state enum {IDLE, READOUT}.
  - Byte-width/LEN helper functions.
  - popcount function.
- Sub-module axis_stat_chan: one channel's byte and frame counters, popcount, clear-and-load on snapshot, saturation logic, shadow registers. Instantiated CHANNELS times via generate.
- Top level holds the tick counter, FSM/pointer mux and skid buffer.

Test Plan (CHANNELS=2, KEEP_WIDTH=8, all counters 32-bit, TAG_WIDTH=16, LEN=22):
- Idle: release rst_n, trigger on edge 11, tag=0xABCD, tready=1 → bytes AB CD 00 00 00 50 then 16×00; tlast on byte 22 only; busy high 22 cycles.
- Counting: ch0 frame of 3 beats with tkeep FF,FF,0F; ch1 single beat tkeep 0x81 with tlast → ch0 bytes=20, frames=1; ch1 bytes=2, frames=1.
- Backpressure: tready alternating 1/0, then held 0 for 20 cycles mid-frame → identical 22-byte sequence, tvalid never drops while data is pending, no duplicates.
- Boundaries: trigger coincident with a ch0 beat (tkeep FF, tlast) → snapshot excludes it, next snapshot shows bytes=8, frames=1. Second trigger during READOUT → ignored, counters keep accumulating.
- Async reset: drop rst_n at byte 9 → tvalid, busy and tlast read 0 before the next edge. A fresh trigger yields a full 22-byte frame of zero counts.
- Saturation, BYTE_COUNT_WIDTH=8, 40 beats tkeep FF on ch0:
  - with AXIS_STAT_SATURATE_EN → byte field 0xFF, tuser=1 on tlast byte.
  - without → 0x40, tuser=0.

Source files
------------

// File: rtl/axis_stat_pkg.sv
// Shared types and elaboration helpers for the axis_stat_counter_mc statistics block.
// Frame geometry is derived here so the top level and any consumer agree on LEN.
package axis_stat_pkg;

  typedef enum logic {IDLE = 1'b0, READOUT = 1'b1} state_t;

  function automatic int xbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int frame_len(input int ch, input int tag_w, input int tick_w,
                                   input int byte_w, input int frame_w);
    return xbytes(tag_w) + xbytes(tick_w) + ch * (xbytes(byte_w) + xbytes(frame_w));
  endfunction

  function automatic int ptr_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // Counts set bits of a keep vector zero-extended to 64 bits.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/axis_stat_chan.sv
// One monitored channel: byte/frame counters with snapshot-and-restart and shadow copies.
// Counters clamp instead of wrapping when AXIS_STAT_SATURATE_EN is defined.
module axis_stat_chan
  import axis_stat_pkg::*;
#(
  parameter int KEEP_WIDTH        = 8,
  parameter int BYTE_COUNT_WIDTH  = 32,
  parameter int FRAME_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [KEEP_WIDTH-1:0]        tkeep,
  input  logic                         tvalid,
  input  logic                         tready,
  input  logic                         tlast,
  input  logic                         snap,
  output logic [BYTE_COUNT_WIDTH-1:0]  byte_shadow,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_shadow,
  output logic                         clamp
);

  localparam int BW = BYTE_COUNT_WIDTH;
  localparam int FW = FRAME_COUNT_WIDTH;

  logic          beat;
  logic [7:0]    keep_cnt;
  logic [BW-1:0] byte_base;
  logic [FW-1:0] frame_base;
  logic [BW:0]   byte_sum;
  logic [FW:0]   frame_sum;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d, byte_sh_q, byte_sh_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_sh_q, frame_sh_d;

  // On snapshot the count restarts from this cycle's own increment.
  always_comb begin
    beat       = tvalid & tready;
    keep_cnt   = beat ? popcount(64'(tkeep)) : 8'd0;
    byte_base  = snap ? '0 : byte_cnt_q;
    frame_base = snap ? '0 : frame_cnt_q;
    byte_sum   = {1'b0, byte_base} + (BW+1)'(keep_cnt);
    frame_sum  = {1'b0, frame_base} + {{FW{1'b0}}, beat & tlast};
`ifdef AXIS_STAT_SATURATE_EN
    byte_cnt_d  = byte_sum[BW]   ? '1 : byte_sum[BW-1:0];
    frame_cnt_d = frame_sum[FW]  ? '1 : frame_sum[FW-1:0];
    clamp       = byte_sum[BW] | frame_sum[FW];
`else
    byte_cnt_d  = byte_sum[BW-1:0];
    frame_cnt_d = frame_sum[FW-1:0];
    clamp       = 1'b0;
`endif
    byte_sh_d  = snap ? byte_cnt_q  : byte_sh_q;
    frame_sh_d = snap ? frame_cnt_q : frame_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      byte_sh_q   <= '0;
      frame_sh_q  <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      byte_sh_q   <= byte_sh_d;
      frame_sh_q  <= frame_sh_d;
    end
  end

  assign byte_shadow  = byte_sh_q;
  assign frame_shadow = frame_sh_q;

endmodule

// File: rtl/axis_stat_counter_mc.sv
// Multi-channel AXI-Stream statistics collector: snapshot on trigger, serialise as a byte stream.
// Define AXIS_STAT_SATURATE_EN for clamping counters and an overflow flag on tuser.
module axis_stat_counter_mc
  import axis_stat_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int KEEP_WIDTH        = 8,
  parameter int TAG_WIDTH         = 16,
  parameter int TICK_COUNT_WIDTH  = 32,
  parameter int BYTE_COUNT_WIDTH  = 32,
  parameter int FRAME_COUNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic [CHANNELS-1:0]            monitor_axis_tvalid,
  input  logic [CHANNELS-1:0]            monitor_axis_tready,
  input  logic [CHANNELS-1:0]            monitor_axis_tlast,
  output logic [7:0]                     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic [TAG_WIDTH-1:0]           tag,
  input  logic                           trigger,
  output logic                           busy
);

  localparam int TAGB   = xbytes(TAG_WIDTH);
  localparam int TICKB  = xbytes(TICK_COUNT_WIDTH);
  localparam int BYTEB  = xbytes(BYTE_COUNT_WIDTH);
  localparam int FRAMEB = xbytes(FRAME_COUNT_WIDTH);
  localparam int CHB    = BYTEB + FRAMEB;
  localparam int LEN    = frame_len(CHANNELS, TAG_WIDTH, TICK_COUNT_WIDTH,
                                    BYTE_COUNT_WIDTH, FRAME_COUNT_WIDTH);
  localparam int PTR_W  = ptr_width(LEN);
  localparam int TW     = TICK_COUNT_WIDTH;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [TW-1:0]           tick_q, tick_d, tick_sh_q, tick_sh_d, tick_base;
  logic [TW:0]             tick_sum;
  logic                    tick_clamp;
  logic [TAG_WIDTH-1:0]    tag_sh_q, tag_sh_d;
  logic                    sticky_q, sticky_d, sticky_sh_q, sticky_sh_d;
  logic                    out_vld_q, out_vld_d, out_last_q, out_last_d, out_user_q, out_user_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    skid_vld_q, skid_vld_d, skid_last_q, skid_last_d, skid_user_q, skid_user_d;
  logic [7:0]              skid_data_q, skid_data_d;

  logic                    snap, push, pop, in_ready;
  logic [7:0]              src_byte;
  logic                    src_last, src_user;
  logic [LEN*8-1:0]        snap_vec;
  logic [CHANNELS-1:0]     chan_clamp;
  logic [BYTE_COUNT_WIDTH-1:0]  byte_sh  [CHANNELS];
  logic [FRAME_COUNT_WIDTH-1:0] frame_sh [CHANNELS];

  assign snap = (state_q == IDLE) & trigger;

  // Snapshot image, most significant byte transmitted first.
  assign snap_vec[LEN*8-1 -: TAGB*8]          = (TAGB*8)'(tag_sh_q);
  assign snap_vec[(LEN-TAGB)*8-1 -: TICKB*8]  = (TICKB*8)'(tick_sh_q);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam int TOP = (LEN - TAGB - TICKB - c*CHB) * 8;

    axis_stat_chan #(
      .KEEP_WIDTH        (KEEP_WIDTH),
      .BYTE_COUNT_WIDTH  (BYTE_COUNT_WIDTH),
      .FRAME_COUNT_WIDTH (FRAME_COUNT_WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .tkeep        (monitor_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]),
      .tvalid       (monitor_axis_tvalid[c]),
      .tready       (monitor_axis_tready[c]),
      .tlast        (monitor_axis_tlast[c]),
      .snap         (snap),
      .byte_shadow  (byte_sh[c]),
      .frame_shadow (frame_sh[c]),
      .clamp        (chan_clamp[c])
    );

    assign snap_vec[TOP-1 -: BYTEB*8]           = (BYTEB*8)'(byte_sh[c]);
    assign snap_vec[TOP-BYTEB*8-1 -: FRAMEB*8]  = (FRAMEB*8)'(frame_sh[c]);
  end

  always_comb begin
    tick_base = snap ? '0 : tick_q;
    tick_sum  = {1'b0, tick_base} + (TW+1)'(KEEP_WIDTH);
`ifdef AXIS_STAT_SATURATE_EN
    tick_d     = tick_sum[TW] ? '1 : tick_sum[TW-1:0];
    tick_clamp = tick_sum[TW];
`else
    tick_d     = tick_sum[TW-1:0];
    tick_clamp = 1'b0;
`endif
    tick_sh_d   = snap ? tick_q : tick_sh_q;
    tag_sh_d    = snap ? tag : tag_sh_q;
    sticky_d    = (snap ? 1'b0 : sticky_q) | (|chan_clamp) | tick_clamp;
    sticky_sh_d = snap ? sticky_q : sticky_sh_q;
  end

  always_comb begin
    src_byte = snap_vec[(LEN - 1 - int'(ptr_q)) * 8 +: 8];
    src_last = (ptr_q == PTR_W'(LEN - 1));
`ifdef AXIS_STAT_SATURATE_EN
    src_user = src_last & sticky_sh_q;
`else
    src_user = 1'b0;
`endif
  end

  // Readout pacing follows the skid buffer's registered ready.
  always_comb begin
    in_ready = ~skid_vld_q;
    push     = (state_q == READOUT) & in_ready;
    state_d  = state_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = READOUT;
          ptr_d   = '0;
        end
      end
      READOUT: begin
        if (push) begin
          if (src_last) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Two-entry skid: the output register is the head, the skid register catches a byte under stall.
  always_comb begin
    pop         = out_vld_q & m_axis_tready;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        out_user_d = skid_user_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = push;
        if (push) begin
          out_data_d = src_byte;
          out_last_d = src_last;
          out_user_d = src_user;
        end
      end
    end else if (push) begin
      skid_vld_d  = 1'b1;
      skid_data_d = src_byte;
      skid_last_d = src_last;
      skid_user_d = src_user;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      tick_q      <= '0;
      tick_sh_q   <= '0;
      tag_sh_q    <= '0;
      sticky_q    <= 1'b0;
      sticky_sh_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      tick_sh_q   <= tick_sh_d;
      tag_sh_q    <= tag_sh_d;
      sticky_q    <= sticky_d;
      sticky_sh_q <= sticky_sh_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_user_q <= skid_user_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_stat_counter_mc.sv
// Directed bench for axis_stat_counter_mc: a 2-channel 32-bit instance plus an 8-bit byte-counter
// instance for the counter boundary case.
module tb_axis_stat_counter_mc;

  localparam int CH = 2;
  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH*KW-1:0]  mon_tkeep;
  logic [CH-1:0]     mon_tvalid, mon_tready, mon_tlast;

  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser, busy, trigger;
  logic [15:0] tag;

  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser, busy2, trigger2;
  logic [15:0] tag2;

  axis_stat_counter_mc #(
    .CHANNELS(CH), .KEEP_WIDTH(KW), .TAG_WIDTH(16), .TICK_COUNT_WIDTH(32),
    .BYTE_COUNT_WIDTH(32), .FRAME_COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .monitor_axis_tkeep(mon_tkeep), .monitor_axis_tvalid(mon_tvalid),
    .monitor_axis_tready(mon_tready), .monitor_axis_tlast(mon_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .tag(tag), .trigger(trigger), .busy(busy)
  );

  axis_stat_counter_mc #(
    .CHANNELS(CH), .KEEP_WIDTH(KW), .TAG_WIDTH(16), .TICK_COUNT_WIDTH(32),
    .BYTE_COUNT_WIDTH(8), .FRAME_COUNT_WIDTH(32)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .monitor_axis_tkeep(mon_tkeep), .monitor_axis_tvalid(mon_tvalid),
    .monitor_axis_tready(mon_tready), .monitor_axis_tlast(mon_tlast),
    .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready),
    .m_axis_tlast(s_tlast), .m_axis_tuser(s_tuser),
    .tag(tag2), .trigger(trigger2), .busy(busy2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int last_trig = 0;

  logic [7:0] cap_d [0:31];
  logic       cap_l [0:31];
  logic       cap_u [0:31];
  logic [7:0] exp_b [0:21];
  int n_got, busy_hi, hold_bad;

  task automatic make_exp(input logic [15:0] t, input logic [31:0] tk,
                          input logic [31:0] b0, input logic [31:0] f0,
                          input logic [31:0] b1, input logic [31:0] f1);
    logic [175:0] v;
    v = {t, tk, b0, f0, b1, f1};
    for (int i = 0; i < 22; i++) exp_b[i] = v[175 - 8*i -: 8];
  endtask

  // Called at a negedge; the trigger is sampled at the following posedge.
  task automatic pulse(input logic [15:0] t, output logic [31:0] tk);
    tk = 32'(8 * (cyc - last_trig));
    last_trig = cyc;
    tag = t;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // mode 0: ready high; 1: alternating; 2: alternating, then 20 cycles of stall, then high.
  task automatic collect(input int sel, input int n, input int mode);
    logic pv, pr, pl, v, l, u, b, r;
    logic [7:0] pd, d;
    int it;
    n_got = 0; busy_hi = 0; hold_bad = 0;
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0; it = 0;
    while (n_got < n && it < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ~it[0];
        default: r = (it < 6) ? ~it[0] : ((it < 26) ? 1'b0 : 1'b1);
      endcase
      if (sel == 0) begin
        m_tready = r; v = m_tvalid; d = m_tdata; l = m_tlast; u = m_tuser; b = busy;
      end else begin
        s_tready = r; v = s_tvalid; d = s_tdata; l = s_tlast; u = s_tuser; b = busy2;
      end
      if (b) busy_hi++;
      if (pv && !pr && (v !== 1'b1 || d !== pd || l !== pl)) hold_bad++;
      if (v === 1'b1 && r) begin
        cap_d[n_got] = d; cap_l[n_got] = l; cap_u[n_got] = u;
        n_got++;
      end
      pv = v; pr = r; pd = d; pl = l;
      @(negedge clk);
      it++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    m_tready = 1'b1; s_tready = 1'b1; trigger = 1'b0; trigger2 = 1'b0;
    tag = '0; tag2 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got=%b want=0", m_tlast); end
    n_cmp++; if (m_tuser !== 1'b0) begin n_bad++; $display("FAIL reset_tuser got=%b want=0", m_tuser); end
    n_cmp++; if (m_tdata !== 8'h00) begin n_bad++; $display("FAIL reset_tdata got=%h want=00", m_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    last_trig = cyc;
  endtask

  task automatic test_idle;
    logic [31:0] tk;
    repeat (10) @(negedge clk);
    pulse(16'hABCD, tk);
    collect(0, 22, 0);
    make_exp(16'hABCD, 32'h0000_0050, 32'd0, 32'd0, 32'd0, 32'd0);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL idle_count got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i] || cap_l[i] !== (i == 21) || cap_u[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_byte%0d got=%h/l%b/u%b want=%h/l%b/u0", i, cap_d[i], cap_l[i], cap_u[i], exp_b[i], (i == 21));
      end
    end
    n_cmp++; if (busy_hi != 22) begin n_bad++; $display("FAIL idle_busy_cycles got=%0d want=22", busy_hi); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL idle_extra_byte got=%b want=0", m_tvalid); end
  endtask

  task automatic test_counting;
    logic [31:0] tk;
    mon_tready = 2'b11;
    mon_tvalid = 2'b11; mon_tkeep = {8'h81, 8'hFF}; mon_tlast = 2'b10;
    @(negedge clk);
    mon_tvalid = 2'b01; mon_tkeep = {8'h00, 8'hFF}; mon_tlast = 2'b00;
    @(negedge clk);
    mon_tkeep = {8'h00, 8'h0F}; mon_tlast = 2'b01;
    @(negedge clk);
    mon_tvalid = '0; mon_tkeep = '0; mon_tlast = '0;
    @(negedge clk);
    pulse(16'h1111, tk);
    collect(0, 22, 0);
    make_exp(16'h1111, tk, 32'd20, 32'd1, 32'd2, 32'd1);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL count_len got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i] || cap_l[i] !== (i == 21)) begin
        n_bad++;
        $display("FAIL count_byte%0d got=%h/l%b want=%h/l%b", i, cap_d[i], cap_l[i], exp_b[i], (i == 21));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] tk;
    pulse(16'hBEEF, tk);
    collect(0, 22, 2);
    make_exp(16'hBEEF, tk, 32'd0, 32'd0, 32'd0, 32'd0);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL bp_len got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i] || cap_l[i] !== (i == 21)) begin
        n_bad++;
        $display("FAIL bp_byte%0d got=%h/l%b want=%h/l%b", i, cap_d[i], cap_l[i], exp_b[i], (i == 21));
      end
    end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold got=%0d violations want=0", hold_bad); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_extra_byte got=%b want=0", m_tvalid); end
  endtask

  task automatic test_boundaries;
    logic [31:0] tk1, tk2;
    m_tready = 1'b0;
    mon_tready = 2'b11; mon_tvalid = 2'b01; mon_tkeep = {8'h00, 8'hFF}; mon_tlast = 2'b01;
    pulse(16'h2222, tk1);
    mon_tvalid = '0; mon_tkeep = '0; mon_tlast = '0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bnd_busy got=%b want=1", busy); end
    tag = 16'h3333; trigger = 1'b1;
    mon_tvalid = 2'b10; mon_tkeep = {8'h03, 8'h00};
    @(negedge clk);
    trigger = 1'b0; mon_tvalid = '0; mon_tkeep = '0;
    collect(0, 22, 0);
    make_exp(16'h2222, tk1, 32'd0, 32'd0, 32'd0, 32'd0);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL bnd1_len got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i]) begin n_bad++; $display("FAIL bnd1_byte%0d got=%h want=%h", i, cap_d[i], exp_b[i]); end
    end
    pulse(16'h4444, tk2);
    collect(0, 22, 0);
    make_exp(16'h4444, tk2, 32'd8, 32'd1, 32'd2, 32'd0);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL bnd2_len got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i]) begin n_bad++; $display("FAIL bnd2_byte%0d got=%h want=%h", i, cap_d[i], exp_b[i]); end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] tk;
    pulse(16'h5555, tk);
    collect(0, 8, 0);
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL ar_byte9_valid got=%b want=1", m_tvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL ar_tvalid got=%b want=0", m_tvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy got=%b want=0", busy); end
    n_cmp++; if (m_tlast !== 1'b0 || m_tdata !== 8'h00) begin n_bad++; $display("FAIL ar_tlast_tdata got=%b/%h want=0/00", m_tlast, m_tdata); end
    @(negedge clk);
    rst_n = 1'b1;
    last_trig = cyc;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL ar_resume got=%b want=0", m_tvalid); end
    pulse(16'h6666, tk);
    collect(0, 22, 0);
    make_exp(16'h6666, tk, 32'd0, 32'd0, 32'd0, 32'd0);
    n_cmp++; if (n_got != 22) begin n_bad++; $display("FAIL ar_len got=%0d want=22", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_b[i] || cap_l[i] !== (i == 21)) begin
        n_bad++;
        $display("FAIL ar_byte%0d got=%h/l%b want=%h/l%b", i, cap_d[i], cap_l[i], exp_b[i], (i == 21));
      end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] want_b;
    logic       want_u;
`ifdef AXIS_STAT_SATURATE_EN
    want_b = 8'hFF; want_u = 1'b1;
`else
    want_b = 8'h40; want_u = 1'b0;
`endif
    s_tready = 1'b1;
    tag2 = 16'h7777; trigger2 = 1'b1;
    @(negedge clk);
    trigger2 = 1'b0;
    repeat (30) @(negedge clk);
    mon_tready = 2'b01; mon_tvalid = 2'b01; mon_tkeep = {8'h00, 8'hFF}; mon_tlast = 2'b00;
    repeat (40) @(negedge clk);
    mon_tvalid = '0; mon_tkeep = '0;
    tag2 = 16'h8888; trigger2 = 1'b1;
    @(negedge clk);
    trigger2 = 1'b0;
    collect(1, 16, 0);
    n_cmp++; if (n_got != 16) begin n_bad++; $display("FAIL sat_len got=%0d want=16", n_got); end
    if (n_got == 16) begin
      n_cmp++; if (cap_d[0] !== 8'h88 || cap_d[1] !== 8'h88) begin n_bad++; $display("FAIL sat_tag got=%h%h want=8888", cap_d[0], cap_d[1]); end
      n_cmp++; if (cap_d[6] !== want_b) begin n_bad++; $display("FAIL sat_bytefield got=%h want=%h", cap_d[6], want_b); end
      n_cmp++; if (cap_u[15] !== want_u || cap_l[15] !== 1'b1) begin n_bad++; $display("FAIL sat_tuser_last got=u%b/l%b want=u%b/l1", cap_u[15], cap_l[15], want_u); end
      for (int i = 0; i < 15; i++) begin
        n_cmp++;
        if (cap_u[i] !== 1'b0 || cap_l[i] !== 1'b0) begin n_bad++; $display("FAIL sat_flags%0d got=u%b/l%b want=u0/l0", i, cap_u[i], cap_l[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_counting();
    test_backpressure();
    test_boundaries();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
